uart_rx: RTL and testbench

- 8N1 UART receiver: the receive-side counterpart of the transmitter inside uart_top.
- Samples the asynchronous serial line at mid-bit using a clock-count bit timer, assembles bytes LSB-first and presents each byte on a valid/ready output port.
- Flags framing errors and overruns.
- Used by the uart bench as a loopback checker on ser_tx, and later as the host-command input path.

---
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx.sv | 153 +++++++++++++++
 tb/tb_uart_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receive-side byte port of the 8N1 UART receiver: valid/ready byte stream plus
// the single-cycle framing-error and overrun pulses.
interface uart_rx_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;

    // The receiver drives the byte and flags; the consumer only answers with ready.
    modport master (
        output out_data,
        output out_valid,
        output frame_err,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  frame_err,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises ser_rx, samples each bit mid-period with a
// clock-count timer and presents assembled bytes on a valid/ready port.
module uart_rx #(
    parameter int clocks_per_bit = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ser_rx,
    uart_rx_if.master rx_out
);

    localparam int HALF = clocks_per_bit / 2;
    localparam int TW   = $clog2(clocks_per_bit);
    localparam logic [TW-1:0] TIMER_FULL = TW'(clocks_per_bit - 1);
    localparam logic [TW-1:0] TIMER_HALF = TW'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [TW-1:0]   timer, timer_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            timer_zero;
    logic            load_byte;
    logic            set_frame_err;
    logic            set_overrun;

    assign rx_s       = sync_q[1];
    assign timer_zero = (timer == '0);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ser_rx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        load_byte     = 1'b0;
        set_frame_err = 1'b0;
        set_overrun   = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    timer_nxt = TIMER_HALF;
                end
            end

            START: begin
                if (!timer_zero) begin
                    timer_nxt = timer - TW'(1);
                end else if (rx_s) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                    timer_nxt   = TIMER_FULL;
                end
            end

            DATA: begin
                if (!timer_zero) begin
                    timer_nxt = timer - TW'(1);
                end else begin
                    shift_nxt[bit_idx] = rx_s;
                    timer_nxt          = TIMER_FULL;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end

            // Returning to IDLE at mid-stop lets a start bit that follows
            // immediately be caught; an accept in the same cycle frees the slot.
            STOP: begin
                if (!timer_zero) begin
                    timer_nxt = timer - TW'(1);
                end else if (rx_s) begin
                    state_nxt = IDLE;
                    if (!rx_out.out_valid || rx_out.out_ready) begin
                        load_byte = 1'b1;
                    end else begin
                        set_overrun = 1'b1;
                    end
                end else begin
                    state_nxt     = BREAK;
                    set_frame_err = 1'b1;
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_out.out_data  <= '0;
            rx_out.out_valid <= 1'b0;
            rx_out.frame_err <= 1'b0;
            rx_out.overrun   <= 1'b0;
        end else begin
            rx_out.frame_err <= set_frame_err;
            rx_out.overrun   <= set_overrun;
            if (load_byte) begin
                rx_out.out_data  <= shift;
                rx_out.out_valid <= 1'b1;
            end else if (rx_out.out_valid && rx_out.out_ready) begin
                rx_out.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 3 clocks per bit: clean frames, overrun,
// framing error with a long break, glitch rejection and mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 3;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic ser_rx = 1'b1;

    int cyc             = 0;
    int checks          = 0;
    int failures        = 0;
    int frame_err_cnt   = 0;
    int overrun_cnt     = 0;
    int first_valid_cyc = -1;
    int frame_start_cyc = 0;
    logic [7:0] rx_q[$];

    uart_rx_if rx_if ();

    uart_rx #(.clocks_per_bit(CPB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ser_rx (ser_rx),
        .rx_out (rx_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: records accepted bytes and counts flag cycles.
    always @(negedge clk) begin
        if (rx_if.out_valid && rx_if.out_ready) rx_q.push_back(rx_if.out_data);
        if (rx_if.frame_err) frame_err_cnt++;
        if (rx_if.overrun) overrun_cnt++;
        if (rx_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        frame_start_cyc = cyc;
        ser_rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            ser_rx = data[i];
            waitCycles(CPB);
        end
        ser_rx = stop_bit;
        waitCycles(CPB);
    endtask

    function automatic int get_byte(input int idx);
        if (idx < rx_q.size()) return int'(rx_q[idx]);
        return -1;
    endfunction

    initial begin
        int base_q;
        int base_fe;
        int base_ov;
        int t1_start;

        rx_if.out_ready = 1'b0;
        waitCycles(3);
        checkOutput("reset_data", int'(rx_if.out_data), 0);
        checkOutput("reset_valid", int'(rx_if.out_valid), 0);
        checkOutput("reset_frame_err", int'(rx_if.frame_err), 0);
        checkOutput("reset_overrun", int'(rx_if.overrun), 0);
        rst_n = 1'b1;
        waitCycles(4);

        // Back-to-back 0x55 / 0xA3 with the consumer always ready.
        rx_if.out_ready = 1'b1;
        base_q  = rx_q.size();
        base_fe = frame_err_cnt;
        base_ov = overrun_cnt;
        applyStimulus(8'h55, 1'b1);
        t1_start = frame_start_cyc;
        applyStimulus(8'hA3, 1'b1);
        waitCycles(8);
        checkOutput("b2b_count", rx_q.size() - base_q, 2);
        checkOutput("b2b_byte0", get_byte(base_q), 8'h55);
        checkOutput("b2b_byte1", get_byte(base_q + 1), 8'hA3);
        checkOutput("b2b_latency", first_valid_cyc - t1_start, 31);
        checkOutput("b2b_frame_err", frame_err_cnt - base_fe, 0);
        checkOutput("b2b_overrun", overrun_cnt - base_ov, 0);

        // Consumer stalled: second byte must be dropped with one overrun pulse.
        rx_if.out_ready = 1'b0;
        base_q  = rx_q.size();
        base_fe = frame_err_cnt;
        base_ov = overrun_cnt;
        applyStimulus(8'h41, 1'b1);
        applyStimulus(8'h42, 1'b1);
        waitCycles(8);
        checkOutput("ovr_data_held", int'(rx_if.out_data), 8'h41);
        checkOutput("ovr_valid_held", int'(rx_if.out_valid), 1);
        checkOutput("ovr_pulse", overrun_cnt - base_ov, 1);
        checkOutput("ovr_frame_err", frame_err_cnt - base_fe, 0);
        rx_if.out_ready = 1'b1;
        waitCycles(1);
        checkOutput("ovr_valid_cleared", int'(rx_if.out_valid), 0);
        checkOutput("ovr_accepted", get_byte(base_q), 8'h41);
        checkOutput("ovr_accept_count", rx_q.size() - base_q, 1);

        // Low stop bit followed by a 50-bit break, then a clean 0x31.
        base_q  = rx_q.size();
        base_fe = frame_err_cnt;
        base_ov = overrun_cnt;
        applyStimulus(8'h7E, 1'b0);
        waitCycles(50 * CPB);
        ser_rx = 1'b1;
        waitCycles(2 * CPB);
        applyStimulus(8'h31, 1'b1);
        waitCycles(8);
        checkOutput("brk_frame_err", frame_err_cnt - base_fe, 1);
        checkOutput("brk_count", rx_q.size() - base_q, 1);
        checkOutput("brk_byte", get_byte(base_q), 8'h31);
        checkOutput("brk_overrun", overrun_cnt - base_ov, 0);

        // Reset during the data bits of 0xFF aborts it; 0x12 follows cleanly.
        base_q = rx_q.size();
        ser_rx = 1'b0;
        waitCycles(CPB);
        ser_rx = 1'b1;
        waitCycles(4 * CPB);
        rst_n = 1'b0;
        waitCycles(2);
        checkOutput("rst_mid_data", int'(rx_if.out_data), 0);
        checkOutput("rst_mid_valid", int'(rx_if.out_valid), 0);
        rst_n = 1'b1;
        waitCycles(12 * CPB);
        checkOutput("rst_no_partial", rx_q.size() - base_q, 0);
        applyStimulus(8'h12, 1'b1);
        waitCycles(8);
        checkOutput("rst_next_count", rx_q.size() - base_q, 1);
        checkOutput("rst_next_byte", get_byte(base_q), 8'h12);

        // One-cycle low glitch is rejected; a following 0x00 frame is received.
        base_q  = rx_q.size();
        base_fe = frame_err_cnt;
        base_ov = overrun_cnt;
        ser_rx = 1'b0;
        waitCycles(1);
        ser_rx = 1'b1;
        waitCycles(10);
        checkOutput("glitch_no_byte", rx_q.size() - base_q, 0);
        applyStimulus(8'h00, 1'b1);
        waitCycles(8);
        checkOutput("glitch_count", rx_q.size() - base_q, 1);
        checkOutput("glitch_byte", get_byte(base_q), 8'h00);
        checkOutput("glitch_flags", (frame_err_cnt - base_fe) + (overrun_cnt - base_ov), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
